moore_seq_driver: RTL and testbench

//  Sequencer for the 2-bit moore_machine: serialises a programmed bit pattern onto the FSM's x input
//  (one bit per clk) and captures the FSM's y output into a parallel result word.

---
 rtl/moore_seq_driver_if.sv | 38 +++
 rtl/moore_seq_driver.sv | 198 +++++++++++++++++++
 tb/tb_moore_seq_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/moore_seq_driver_if.sv
// Host-side bus of moore_seq_driver: start/pattern/len request, busy/done/err/result status.
// MOORE_SEQ_CHECK_EN adds expected (request) plus match/mismatch_cnt (status).
interface moore_seq_driver_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CW-1:0]    len;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
`ifdef MOORE_SEQ_CHECK_EN
  logic [WIDTH-1:0] expected;
  logic             match;
  logic [CW-1:0]    mismatch_cnt;

  modport master (
    output start, pattern, len, expected,
    input  busy, done, err, result, match, mismatch_cnt
  );
  modport slave (
    input  start, pattern, len, expected,
    output busy, done, err, result, match, mismatch_cnt
  );
`else
  modport master (
    output start, pattern, len,
    input  busy, done, err, result
  );
  modport slave (
    input  start, pattern, len,
    output busy, done, err, result
  );
`endif
endinterface

// File: rtl/moore_seq_driver.sv
// Serialises pattern onto moore_machine.x, captures y into result; done after len+RESP_LAT+1 edges.
// start is ignored while busy or in DONE; a bad len pulses err. MOORE_SEQ_CHECK_EN adds the compare.
module moore_seq_driver #(
  parameter int WIDTH    = 8,
  parameter int RESP_LAT = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  output logic              x,
  input  logic              y,
  moore_seq_driver_if.slave host
);

  localparam int CW  = $clog2(WIDTH + 1);
  // t runs up to len+RESP_LAT, so it is sized for that rather than for len
  localparam int TW  = $clog2(WIDTH + RESP_LAT + 2);
  localparam int TW1 = TW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TW-1:0]    t_cnt;
  logic [TW-1:0]    t_nxt;
  logic [TW-1:0]    len_t;
  logic [TW:0]      lag_t;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_nxt;
  logic [CW-1:0]    len_q;
  logic             x_q;
  logic             x_nxt;
  logic             err_q;
  logic             err_nxt;
  logic             accept;
  logic             len_ok;
  logic             in_window;
  logic             cap_en;
  logic             last_send;
  logic             last_drain;

  assign len_ok     = (host.len != '0) && (host.len <= CW'(WIDTH));
  assign len_t      = TW'(len_q);
  // lag_t = t - RESP_LAT: index of the pattern bit whose response is on y now
  assign lag_t      = {1'b0, t_cnt} - TW1'(RESP_LAT);
  assign in_window  = (state == SEND) || (state == DRAIN);
  assign cap_en     = in_window && !lag_t[TW] && (lag_t[TW-1:0] < len_t);
  assign last_send  = (t_cnt == len_t - TW'(1));
  assign last_drain = (t_cnt == len_t + TW'(RESP_LAT) - TW'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    t_nxt      = t_cnt;
    x_nxt      = 1'b0;
    err_nxt    = 1'b0;
    accept     = 1'b0;
    result_nxt = result_q;

    for (int j = 0; j < WIDTH; j++) begin
      if (cap_en && (lag_t[TW-1:0] == TW'(j))) begin
        result_nxt[j] = y;
      end
    end

    case (state)
      IDLE: begin
        t_nxt = '0;
        if (host.start) begin
          if (len_ok) begin
            accept     = 1'b1;
            state_nxt  = SEND;
            result_nxt = '0;
            x_nxt      = host.pattern[0];
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        t_nxt = t_cnt + TW'(1);
        if (last_send) begin
          if (RESP_LAT > 0) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          for (int j = 0; j < WIDTH; j++) begin
            if (t_nxt == TW'(j)) begin
              x_nxt = pat_q[j];
            end
          end
        end
      end
      DRAIN: begin
        t_nxt = t_cnt + TW'(1);
        if (last_drain) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      t_cnt    <= '0;
      x_q      <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      pat_q    <= '0;
      len_q    <= '0;
    end else begin
      t_cnt    <= t_nxt;
      x_q      <= x_nxt;
      err_q    <= err_nxt;
      result_q <= result_nxt;
      if (accept) begin
        pat_q <= host.pattern;
        len_q <= host.len;
      end
    end
  end

  assign x           = x_q;
  assign host.busy   = in_window;
  assign host.done   = (state == DONE);
  assign host.err    = err_q;
  assign host.result = result_q;

`ifdef MOORE_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic [CW-1:0]    mm_q;
  logic [CW-1:0]    mm_nxt;
  logic             match_q;
  logic             match_nxt;
  logic             exp_bit;

  // mismatch count includes the capture on the edge into DONE, so match uses mm_nxt
  always_comb begin
    exp_bit   = 1'b0;
    mm_nxt    = mm_q;
    match_nxt = match_q;
    for (int j = 0; j < WIDTH; j++) begin
      if (lag_t[TW-1:0] == TW'(j)) begin
        exp_bit = exp_q[j];
      end
    end
    if (cap_en && (y != exp_bit)) begin
      mm_nxt = mm_q + CW'(1);
    end
    if (accept) begin
      mm_nxt    = '0;
      match_nxt = 1'b0;
    end else if ((state != DONE) && (state_nxt == DONE)) begin
      match_nxt = (mm_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q   <= '0;
      mm_q    <= '0;
      match_q <= 1'b0;
    end else begin
      mm_q    <= mm_nxt;
      match_q <= match_nxt;
      if (accept) begin
        exp_q <= host.expected;
      end
    end
  end

  assign host.match        = match_q;
  assign host.mismatch_cnt = mm_q;
`endif

endmodule

// File: tb/tb_moore_seq_driver.sv
// Bench for moore_seq_driver with a 1-clk loopback standing in for moore_machine (WIDTH=8, RESP_LAT=1).
// Table vectors, reset/err/abort sequences, then random ops against a pattern-level model.
module tb_moore_seq_driver;

  logic clk;
  logic n_rst;
  logic x;
  logic y;
  logic inv_loop;
  int   n_checks;
  int   n_fail;
  logic [7:0] last_result;

  moore_seq_driver_if #(.WIDTH(8)) bus ();

  moore_seq_driver #(.WIDTH(8), .RESP_LAT(1)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .x     (x),
    .y     (y),
    .host  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Loopback plant: y is x delayed one clock, optionally inverted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) y <= 1'b0;
    else        y <= x ^ inv_loop;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic       inv;
    logic       hold;
    logic [7:0] exp_pat;
    logic [7:0] exp_result;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_result(input logic [7:0] pat, input int ln, input logic inv);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < ln; j++) r[j] = pat[j] ^ inv;
    return r;
  endfunction

  function automatic int model_mm(input logic [7:0] pat, input logic [7:0] expv, input int ln,
                                  input logic inv);
    int c;
    c = 0;
    for (int j = 0; j < ln; j++) if ((pat[j] ^ inv) != expv[j]) c++;
    return c;
  endfunction

  task automatic run_op(input logic [7:0] pat, input logic [3:0] ln, input logic inv,
                        input logic hold, input logic [7:0] exp_pat, input logic [7:0] exp_result);
    int n;
    n = int'(ln);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = ln;
    inv_loop    = inv;
`ifdef MOORE_SEQ_CHECK_EN
    bus.expected = exp_pat;
`endif
    @(posedge clk); #1;
    if (hold) bus.len = '0;
    else      bus.start = 1'b0;
    check("result_clear", 32'(bus.result), 32'h0);
    for (int t = 0; t <= n + 1; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      check("x", 32'(x), (t < n) ? 32'(pat[t]) : 32'h0);
      check("busy", 32'(bus.busy), 32'(t <= n));
      check("done", 32'(bus.done), 32'(t == n + 1));
      check("err_busy", 32'(bus.err), 32'h0);
    end
    bus.start = 1'b0;
    check("result", 32'(bus.result), 32'(exp_result));
`ifdef MOORE_SEQ_CHECK_EN
    check("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(model_mm(pat, exp_pat, n, inv)));
    check("match", 32'(bus.match), 32'(model_mm(pat, exp_pat, n, inv) == 0));
`endif
    last_result = exp_result;
    @(posedge clk); #1;
    check("done_after", 32'(bus.done), 32'h0);
    check("busy_after", 32'(bus.busy), 32'h0);
    check("result_hold", 32'(bus.result), 32'(last_result));
  endtask

  task automatic bad_start(input logic [3:0] ln);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = ln;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("err_pulse", 32'(bus.err), 32'h1);
    check("err_busy0", 32'(bus.busy), 32'h0);
    check("err_x0", 32'(x), 32'h0);
    check("err_result", 32'(bus.result), 32'(last_result));
    @(posedge clk); #1;
    check("err_clear", 32'(bus.err), 32'h0);
    check("err_idle", 32'(bus.busy), 32'h0);
  endtask

  vec_t tbl[6];

  initial begin
    logic [7:0] rp;
    logic [7:0] re;
    logic [3:0] rl;
    logic       ri;
    logic       rh;

    tbl[0] = '{8'hA5, 4'd8, 1'b0, 1'b0, 8'hA5, 8'hA5};
    tbl[1] = '{8'hFF, 4'd3, 1'b0, 1'b0, 8'hFF, 8'h07};
    tbl[2] = '{8'h80, 4'd8, 1'b0, 1'b1, 8'h80, 8'h80};
    tbl[3] = '{8'h01, 4'd1, 1'b0, 1'b0, 8'h00, 8'h01};
    tbl[4] = '{8'hA5, 4'd8, 1'b1, 1'b0, 8'hA5, 8'h5A};
    tbl[5] = '{8'h5A, 4'd4, 1'b1, 1'b1, 8'h5A, 8'h05};

    n_checks    = 0;
    n_fail      = 0;
    last_result = '0;
    inv_loop    = 1'b0;
    n_rst       = 1'b0;
    bus.start   = 1'b1;
    bus.pattern = 8'hA5;
    bus.len     = 4'd8;
`ifdef MOORE_SEQ_CHECK_EN
    bus.expected = 8'hA5;
`endif

    // Reset held with start asserted: everything stays quiet
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_x", 32'(x), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      check("rst_result", 32'(bus.result), 32'h0);
`ifdef MOORE_SEQ_CHECK_EN
      check("rst_match", 32'(bus.match), 32'h0);
      check("rst_mm", 32'(bus.mismatch_cnt), 32'h0);
`endif
    end
    bus.start = 1'b0;
    n_rst     = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].pat, tbl[i].len, tbl[i].inv, tbl[i].hold, tbl[i].exp_pat, tbl[i].exp_result);
    end

    bad_start(4'd0);
    bad_start(4'd9);

    // Abort during SEND t=4 of the A5 run
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.pattern = 8'hA5;
    bus.len     = 4'd8;
    inv_loop    = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort_busy_pre", 32'(bus.busy), 32'h1);
    n_rst = 1'b0;
    #1;
    check("abort_x", 32'(x), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_result", 32'(bus.result), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_done", 32'(bus.done), 32'h0);
    end
    n_rst       = 1'b1;
    last_result = '0;
    run_op(8'hA5, 4'd8, 1'b0, 1'b0, 8'hA5, 8'hA5);

    for (int i = 0; i < 24; i++) begin
      rp = 8'($urandom);
      re = 8'($urandom);
      rl = 4'($urandom_range(1, 8));
      ri = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      run_op(rp, rl, ri, rh, re, model_result(rp, int'(rl), ri));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
